// File: rtl/branch_zero_seq.sv
// branch_zero_seq: nibble-serial branch-condition sequencer for BEQZ/BNEZ.
// Latches the operand, target and PC, scans the operand NIB bits per cycle
// starting at the LSB nibble, and reports ZERO/TAKEN/NEXT_PC with a
// one-cycle DONE pulse. It can stop at the first non-zero nibble.
module branch_zero_seq #(
  parameter int WIDTH      = 32,
  parameter int NIB        = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             bnez_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] pc_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o,
  output logic             taken_o,
  output logic [WIDTH-1:0] next_pc_o
);

  localparam int NUM = WIDTH / NIB;
  localparam int KW  = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic             nz_q;
  logic [WIDTH-1:0] opnd_q;
  logic             bnez_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] pc_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             taken_q;
  logic [WIDTH-1:0] next_pc_q;

  logic [NIB-1:0]   cur_nib;
  logic             nib_nz;
  logic             nz_d;
  logic             taken_d;
  logic             last_d;
  logic             exit_d;
  logic [WIDTH-1:0] next_pc_d;

  // Select the shadow nibble under test and form the exit decision/results.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    cur_nib = '0;
    for (int i = 0; i < NUM; i++) begin
      if (k_q == KW'(i)) cur_nib = opnd_q[i*NIB +: NIB];
    end
    nib_nz    = (cur_nib != '0);
    nz_d      = nz_q | nib_nz;
    last_d    = (k_q == KW'(NUM - 1));
    exit_d    = last_d || (nib_nz && EARLY_EXIT);
    taken_d   = bnez_q ? nz_d : ~nz_d;
    next_pc_d = taken_d ? tgt_q : (pc_q + WIDTH'(4));
  end

  // Control FSM with registered outputs; results are only updated on entry
  // to DONE so they hold through any later SCAN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      nz_q      <= 1'b0;
      opnd_q    <= '0;
      bnez_q    <= 1'b0;
      tgt_q     <= '0;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would create order-dependent races.
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            opnd_q  <= opnd_i;
            bnez_q  <= bnez_i;
            tgt_q   <= tgt_i;
            pc_q    <= pc_in_i;
            k_q     <= '0;
            nz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          nz_q <= nz_d;
          if (exit_d) begin
            done_q    <= 1'b1;
            zero_q    <= ~nz_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            state_q   <= ST_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign zero_o    = zero_q;
  assign taken_o   = taken_q;
  assign next_pc_o = next_pc_q;

endmodule

// File: tb/tb_branch_zero_seq.sv
// Testbench for branch_zero_seq: early-exit and full-scan builds share the
// data inputs; a scoreboard queue per build holds expected results.
module tb_branch_zero_seq;

  localparam int W = 32;

  typedef struct {
    logic        zero;
    logic        taken;
    logic [31:0] npc;
    int          e0;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req1 = 1'b0, req0 = 1'b0;
  logic [W-1:0]  opnd = '0, tgt = '0, pc = '0;
  logic          bnez = 1'b0;

  logic          busy1, done1, zero1, taken1;
  logic [W-1:0]  npc1;
  logic          busy0, done0, zero0, taken0;
  logic [W-1:0]  npc0;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_zero_seq #(.WIDTH(W), .NIB(4), .EARLY_EXIT(1'b1)) dut_ee1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .opnd_i(opnd), .bnez_i(bnez),
    .tgt_i(tgt), .pc_in_i(pc), .busy_o(busy1), .done_o(done1),
    .zero_o(zero1), .taken_o(taken1), .next_pc_o(npc1));

  branch_zero_seq #(.WIDTH(W), .NIB(4), .EARLY_EXIT(1'b0)) dut_ee0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .opnd_i(opnd), .bnez_i(bnez),
    .tgt_i(tgt), .pc_in_i(pc), .busy_o(busy0), .done_o(done0),
    .zero_o(zero0), .taken_o(taken0), .next_pc_o(npc0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: result and latency of one request.
  function automatic exp_t model(input bit ee, input logic [31:0] o, input logic b,
                                 input logic [31:0] t, input logic [31:0] p);
    exp_t e;
    logic nz;
    int   first;
    nz    = (o != 0);
    first = 8;
    for (int j = 7; j >= 0; j--) if (((o >> (4*j)) & 32'hF) != 0) first = j;
    e.zero  = ~nz;
    e.taken = b ? nz : ~nz;
    e.npc   = e.taken ? t : p + 32'd4;
    e.lat   = (ee && nz) ? first + 1 : 8;
    e.e0    = 0;
    return e;
  endfunction

  // Scoreboard monitors: compare when a DONE pulse is seen.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) check("ee1_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("ee1_latency", 32'(cyc - e.e0), 32'(e.lat));
        check("ee1_zero", {31'd0, zero1}, {31'd0, e.zero});
        check("ee1_taken", {31'd0, taken1}, {31'd0, e.taken});
        check("ee1_next_pc", npc1, e.npc);
      end
    end
    if (done0) begin
      if (q0.size() == 0) check("ee0_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("ee0_latency", 32'(cyc - e.e0), 32'(e.lat));
        check("ee0_zero", {31'd0, zero0}, {31'd0, e.zero});
        check("ee0_taken", {31'd0, taken0}, {31'd0, e.taken});
        check("ee0_next_pc", npc0, e.npc);
      end
    end
  end

  // Drive a request at a negedge, push its expectation, drop REQ after e0.
  task automatic start_req(input bit ee, input logic [31:0] o, input logic b,
                           input logic [31:0] t, input logic [31:0] p);
    exp_t e;
    @(negedge clk);
    opnd = o; bnez = b; tgt = t; pc = p;
    if (ee) req1 = 1'b1; else req0 = 1'b1;
    e    = model(ee, o, b, t, p);
    e.e0 = cyc + 1;
    if (ee) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    req1 = 1'b0; req0 = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard for the chosen build has drained.
  task automatic wait_done(input bit ee);
    int n;
    n = 0;
    while ((ee ? q1.size() : q0.size()) != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if ((ee ? q1.size() : q0.size()) != 0) begin
      check(ee ? "ee1_timeout" : "ee0_timeout", 32'd1, 32'd0);
      if (ee) q1.delete(); else q0.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_zero", {31'd0, zero1}, 32'd0);
    check("rst_taken", {31'd0, taken1}, 32'd0);
    check("rst_next_pc", npc1, 32'd0);
    rst = 1'b0;

    // BNEZ early exit on the low nibble.
    start_req(1'b1, 32'h0000_0001, 1'b1, 32'h0000_2000, 32'h0000_0100);
    wait_done(1'b1);

    // Reset mid-SCAN clears everything immediately and no DONE follows.
    @(negedge clk);
    opnd = 32'h0; bnez = 1'b0; tgt = 32'h1000; pc = 32'h200; req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy1}, 32'd0);
    check("midrst_done", {31'd0, done1}, 32'd0);
    check("midrst_zero", {31'd0, zero1}, 32'd0);
    check("midrst_taken", {31'd0, taken1}, 32'd0);
    check("midrst_next_pc", npc1, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);

    // BEQZ zero operand: full scan, taken.
    start_req(1'b1, 32'h0000_0000, 1'b0, 32'h0000_1000, 32'h0000_0200);
    wait_done(1'b1);

    // BEQZ, only the top nibble non-zero: fall-through wraps to 0.
    start_req(1'b1, 32'h8000_0000, 1'b0, 32'h0000_4000, 32'hFFFF_FFFC);
    wait_done(1'b1);

    // A REQ during SCAN is ignored; results hold until the next DONE.
    start_req(1'b1, 32'h0000_0F00, 1'b0, 32'h0000_3000, 32'h0000_0400);
    opnd = 32'h0; req1 = 1'b1;
    @(negedge clk); req1 = 1'b0;
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("hold_zero", {31'd0, zero1}, 32'd0);
    check("hold_taken", {31'd0, taken1}, 32'd0);
    check("hold_next_pc", npc1, 32'h0000_0404);
    start_req(1'b1, 32'h0000_0000, 1'b0, 32'h0000_5000, 32'h0000_0600);
    @(negedge clk);
    check("scan_busy", {31'd0, busy1}, 32'd1);
    check("scan_hold_zero", {31'd0, zero1}, 32'd0);
    check("scan_hold_next_pc", npc1, 32'h0000_0404);
    wait_done(1'b1);

    // Random operands with a few sparse nibbles, both BEQZ and BNEZ.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] o;
      o = (i % 3 == 0) ? 32'h0 : ($urandom & (32'hF << (4 * $urandom_range(0, 7))));
      start_req(1'b1, o, 1'(i & 1), $urandom, $urandom);
      wait_done(1'b1);
    end

    // Full-scan build: no early exit even on a non-zero nibble.
    start_req(1'b0, 32'h0000_0010, 1'b1, 32'h0000_7000, 32'h0000_0800);
    wait_done(1'b0);
    start_req(1'b0, 32'h0000_0000, 1'b1, 32'h0000_7000, 32'hFFFF_FFFC);
    wait_done(1'b0);

    check("sb_empty", 32'(q1.size() + q0.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_zero_seq.md
# branch_zero_seq

Nibble-serial branch-condition sequencer for the DLX conditional-branch path (BEQZ/BNEZ). It latches a 32-bit register operand with its branch target and fall-through PC, and tests the operand 4 bits per cycle, LSB nibble first. It exits early on the first non-zero nibble, then reports the zero flag, the branch decision and the next PC for one DONE cycle. It lets the 4-bit I/O build resolve branches without a full-width zero detector on the critical path.

## Interface
- WIDTH, 32, operand/PC width; must be a multiple of NIB
- NIB, 4, bits tested per SCAN cycle
- EARLY_EXIT, 1, 1 = leave SCAN on first non-zero nibble; 0 = always scan all WIDTH/NIB nibbles

- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  start request; sampled only in IDLE
- OPND  in  WIDTH  register value to test
- BNEZ  in  1  0 = BEQZ (taken if zero), 1 = BNEZ (taken if non-zero)
- TGT  in  WIDTH  branch target address
- PC_IN  in  WIDTH  address of the branch instruction
- BUSY  out  1  high in SCAN and DONE
- DONE  out  1  one-cycle pulse; result outputs valid
- ZERO  out  1  latched operand was all zeros
- TAKEN  out  1  branch decision
- NEXT_PC  out  WIDTH  TAKEN ? TGT : PC_IN + 4 (mod 2^WIDTH)

## Operation
- States: IDLE, SCAN, DONE; reset state IDLE.
- IDLE: on REQ=1, latch OPND, BNEZ, TGT, PC_IN into shadow registers, clear nibble counter k (log2(WIDTH/NIB) bits), go to SCAN. If REQ=0, stay.
- SCAN: each cycle test shadow nibble k (bits NIB*k+NIB-1 : NIB*k) against 0.
  - Non-zero and EARLY_EXIT=1: set nz flag, go to DONE.
  - Non-zero and EARLY_EXIT=0: set nz flag, continue.
  - k = WIDTH/NIB-1 (last nibble): go to DONE.
  - Otherwise: k <= k+1.
- Entering DONE registers the results: ZERO = ~nz; TAKEN = BNEZ ? nz : ~nz; NEXT_PC per the interface rule, with PC_IN+4 wrapping modulo 2^WIDTH.
- DONE: DONE=1 for exactly one cycle, then unconditionally to IDLE.
- ZERO, TAKEN and NEXT_PC hold their values until the next DONE. They do not change while a later request is in SCAN.
- REQ asserted while BUSY=1 is ignored; it is neither queued nor re-sampled. REQ held high through DONE starts a new request in the IDLE cycle that follows.
- Input changes after the latching edge have no effect on the current operation.
- RST, asynchronous at any time including mid-SCAN:
  - state IDLE, k=0, nz=0;
  - BUSY=0, DONE=0, ZERO=0, TAKEN=0, NEXT_PC=0;
  - shadow registers cleared.

## Timing
- Edge e0 samples REQ in IDLE. Edge e(j+1) evaluates nibble j.
- Latency from e0 to DONE rising:
  - first non-zero nibble j, EARLY_EXIT=1: j+1 cycles (minimum 1);
  - operand zero, or EARLY_EXIT=0: WIDTH/NIB cycles (8 at defaults).
- DONE is high for the single cycle after it rises.
- Back-to-back throughput: latency + 2 cycles per request (DONE cycle + IDLE sample cycle).
- BUSY rises the cycle after e0 and falls with DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-SCAN: REQ with OPND=0, assert RST after 3 cycles -> BUSY, DONE, ZERO, TAKEN, NEXT_PC all 0 immediately; no DONE afterwards.
- BEQZ zero operand: OPND=0x00000000, BNEZ=0, TGT=0x1000, PC_IN=0x0200 -> DONE 8 cycles after e0, ZERO=1, TAKEN=1, NEXT_PC=0x1000.
- BNEZ early exit on low nibble: OPND=0x00000001, BNEZ=1, TGT=0x2000 -> DONE 1 cycle after e0, ZERO=0, TAKEN=1, NEXT_PC=0x2000.
- BEQZ, top nibble non-zero: OPND=0x80000000, BNEZ=0, PC_IN=0xFFFFFFFC -> DONE 8 cycles after e0, ZERO=0, TAKEN=0, NEXT_PC=0x00000000 (wrap).
- Busy-ignore and hold: second REQ with OPND=0 during SCAN of OPND=0x00000F00 -> one DONE after 3 cycles, ZERO=0; outputs unchanged until a fresh REQ in IDLE.
- EARLY_EXIT=0 build: OPND=0x00000010 -> DONE after 8 cycles, ZERO=0.
